// File: rtl/dpbr_arb_pkg.sv
// Shared constants and types for the DPBR1K08 port-A arbiter.
package dpbr_arb_pkg;

    localparam int unsigned DPBR_AW       = 10;
    localparam int unsigned DPBR_DW       = 9;
    localparam int unsigned DPBR_MAXBURST = 4;
    localparam int unsigned DPBR_NREQ_MAX = 4;
    localparam int unsigned DPBR_IDXW     = $clog2(DPBR_NREQ_MAX);

    // Requester index, wide enough for the largest supported NREQ.
    typedef logic [DPBR_IDXW-1:0] idx_t;

    // Burst counter saturation value.
    localparam logic [3:0] BCNT_SAT = 4'hF;

endpackage

// File: rtl/dpbr1k08_arb_rr_pick.sv
// Rotating-priority picker: first valid requester at or after i_start, modulo N.
module rr_pick
    import dpbr_arb_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] i_valid,
    input  idx_t         i_start,
    output logic [N-1:0] o_grant,
    output idx_t         o_idx,
    output logic         o_any
);

    // Scan N positions starting at i_start, keep the first hit.
    always_comb begin
        int unsigned w_pos;
        w_pos   = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = (int'(i_start) + k) % N;
            if (!o_any && i_valid[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = idx_t'(w_pos);
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpbr1k08_arb.sv
// Port-A arbiter for DPBR1K08: round-robin with bounded burst retention,
// direct RAM drive and tagged read-data return.
module dpbr1k08_arb
    import dpbr_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned AW       = DPBR_AW,
    parameter int unsigned DW       = DPBR_DW,
    parameter int unsigned MAXBURST = DPBR_MAXBURST
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               ram_ce,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_di,
    input  logic [DW-1:0]      ram_do
);

    localparam logic [3:0] MB = 4'(MAXBURST);

    idx_t           r_owner;
    logic [3:0]     r_bcnt;
    logic           r_rd_pend;
    idx_t           r_rd_tag;

    idx_t           w_start;
    idx_t           w_pick_idx;
    logic [NREQ-1:0] w_pick_gnt;
    logic           w_pick_any;
    logic           w_hold;
    logic [NREQ-1:0] w_gnt;
    idx_t           w_gidx;
    logic           w_any;

    // Scan start (owner+1 mod NREQ) and burst-retention decision.
    // bcnt == 0 only occurs out of reset: owner has never been granted,
    // so the scan starts at requester 0 instead of retaining NREQ-1.
    always_comb begin
        w_start = (r_owner == idx_t'(NREQ-1)) ? '0 : r_owner + idx_t'(1);
        w_hold  = req_valid[r_owner] && (r_bcnt != '0) && (r_bcnt < MB);
    end

    rr_pick #(
        .N(NREQ)
    ) u_pick (
        .i_valid (req_valid),
        .i_start (w_start),
        .o_grant (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Final grant: retain owner, else rotating pick; nothing while in reset.
    always_comb begin
        w_gnt  = '0;
        w_gidx = r_owner;
        w_any  = 1'b0;
        if (rst_n) begin
            if (w_hold) begin
                w_gnt[r_owner] = 1'b1;
                w_any          = 1'b1;
            end else if (w_pick_any) begin
                w_gnt  = w_pick_gnt;
                w_gidx = w_pick_idx;
                w_any  = 1'b1;
            end
        end
        req_ready = w_gnt;
    end

    // RAM port A driven straight from the granted requester.
    always_comb begin
        ram_ce   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (w_any) begin
            ram_ce   = 1'b1;
            ram_we   = req_we[w_gidx];
            ram_addr = req_addr[w_gidx*AW +: AW];
            ram_di   = req_wdata[w_gidx*DW +: DW];
        end
    end

    // Owner/burst tracking and outstanding-read bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= idx_t'(NREQ-1);
            r_bcnt    <= '0;
            r_rd_pend <= 1'b0;
            r_rd_tag  <= '0;
        end else if (w_any) begin
            if (w_gidx == r_owner) begin
                r_bcnt <= (r_bcnt == BCNT_SAT) ? r_bcnt : r_bcnt + 4'd1;
            end else begin
                r_owner <= w_gidx;
                r_bcnt  <= 4'd1;
            end
            r_rd_pend <= ~ram_we;
            r_rd_tag  <= w_gidx;
        end else begin
            r_rd_pend <= 1'b0;
        end
    end

    // Read response routed by tag; data passes through from the RAM.
    always_comb begin
        rsp_valid = '0;
        if (r_rd_pend) begin
            rsp_valid[r_rd_tag] = 1'b1;
        end
        rsp_rdata = ram_do;
    end

endmodule

// File: doc/dpbr1k08_arb.md
# dpbr1k08_arb

Arbiter that shares port A of the 1K×9 dual-port block RAM (`DPBR1K08`) between `NREQ` requesters, such as the CPU load/store path, DMA and a debug/UART loader. It grants one access per cycle using round-robin with bounded burst retention. It drives the RAM port directly and routes read data back to the requester that issued the read. Port B of the RAM is outside this block.

## Interface
Parameters:
- `NREQ`, 3, number of requesters (2..4).
- `AW`, 10, RAM address width.
- `DW`, 9, RAM data width.
- `MAXBURST`, 4, maximum consecutive grants to one requester while others wait (1..15).

Ports:
- `clk`  in  1  single clock, shared with RAM `clka`.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `req_valid`  in  NREQ  per-requester access request.
- `req_ready`  out  NREQ  one-hot grant; an access is accepted when `req_valid[i] & req_ready[i]`.
- `req_we`  in  NREQ  1 = write, 0 = read.
- `req_addr`  in  NREQ*AW  packed addresses; requester i occupies bits `[i*AW +: AW]`.
- `req_wdata`  in  NREQ*DW  packed write data.
- `rsp_valid`  out  NREQ  one-hot read-data strobe.
- `rsp_rdata`  out  DW  read data, shared by all requesters and qualified by `rsp_valid`.
- `ram_ce`  out  1  to RAM `cea`.
- `ram_we`  out  1  to RAM `wea`.
- `ram_addr`  out  AW  to RAM `addra`.
- `ram_di`  out  DW  to RAM `dia`.
- `ram_do`  in  DW  from RAM `doa`; NOREG, valid the cycle after the read edge.

## Operation
- State:
  - `owner` (clog2(NREQ) bits): last granted index.
  - `bcnt` (4 bits): consecutive grants to `owner`.
  - `rd_pend` (1 bit) and `rd_tag` (clog2 bits): outstanding read.
- Grant selection (combinational, every cycle):
  - If `req_valid[owner]` and `bcnt < MAXBURST`, grant `owner`.
  - Otherwise scan from `owner+1` upward, modulo NREQ, and grant the first valid requester.
  - No valid requester means no grant, and `req_ready` is all zero.
  - `req_ready` depends only on `req_valid`, `owner` and `bcnt`. It never depends on `req_we`, address or data.
- RAM drive (combinational from the granted requester):
  - `ram_ce` = any grant.
  - `ram_we`, `ram_addr`, `ram_di` = the granted requester's fields.
  - With no grant: `ram_ce` = 0, `ram_we` = 0, `ram_addr` and `ram_di` = 0.
- On a grant to requester g, at the clock edge:
  - If g == `owner`: `bcnt` <= `bcnt` + 1, saturating at 15.
  - Else: `owner` <= g and `bcnt` <= 1.
  - If the access is a read: `rd_pend` <= 1 and `rd_tag` <= g. Otherwise `rd_pend` <= 0.
- With no grant in a cycle: `rd_pend` <= 0; `owner` and `bcnt` hold.
- Response path:
  - `rsp_valid[rd_tag]` = `rd_pend`; all other bits are 0.
  - `rsp_rdata` = `ram_do` unconditionally.
  - Responses cannot stall. Requesters must consume read data in the cycle `rsp_valid` is high.
- Writes produce no response. The RAM runs in NORMAL write mode, so `doa` is don't-care after a write.
- Reset values:
  - `owner` = NREQ-1, so the first scan starts at requester 0.
  - `bcnt` = 0, `rd_pend` = 0.
  - All `rsp_valid` bits = 0 and all `req_ready` bits = 0 while `rst_n` is low.

## Timing
- Accept to RAM capture: same edge (0 cycles added).
- Read latency: `rsp_valid` is high exactly 1 cycle after the accepting edge.
- Sustained throughput: 1 access per cycle. Back-to-back reads from different requesters give consecutive `rsp_valid` bits, each routed by its own `rd_tag`.
- Fairness: a requester with `req_valid` held high is granted within (NREQ-1)·MAXBURST cycles.
- A burst owner dropping `req_valid` releases immediately; the next cycle grants from `owner+1`.
- MAXBURST = 1 gives pure round-robin.
- Reset asserted mid-read: `rd_pend` clears asynchronously and the pending `rsp_valid` is lost. Requesters must discard outstanding reads on reset.
- Simultaneous requests after an idle period: the scan starts from `owner+1`, not from 0.

## Structure
- Package `dpbr_arb_pkg`:
  - `DPBR_AW` = 10 and `DPBR_DW` = 9.
  - Default `MAXBURST`.
  - An `idx_t` typedef sized clog2 of the maximum NREQ (4).
- Sub-module `rr_pick`: combinational rotating priority picker. Inputs are the `valid` vector and a start index; outputs are a one-hot grant and an index. The top level wraps it with the owner/burst logic.
- The RAM is not instantiated inside the block. The SoC top connects the `ram_*` ports to `DPBR1K08` port A.

## Test plan
- Reset release with all `req_valid` low → `req_ready` = 0, `rsp_valid` = 0, `ram_ce` = 0.
- Requester 0 writes 9'h1A5 to address 10'h3FF, then reads address 10'h3FF → `rsp_valid` = 3'b001 one cycle after the read grant, with `rsp_rdata` = 9'h1A5.
- All three requesters hold `req_valid` with MAXBURST = 4 → grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0…
- Requester 1 deasserts after 2 beats while requester 2 is waiting → the next grant goes to 2 and `bcnt` = 1.
- Interleaved reads: requester 2 reads address 5 and requester 0 reads address 6 on consecutive cycles → `rsp_valid` goes 3'b100 then 3'b001, each with its own address's data.
- Assert `rst_n` low in the cycle after a read grant → `rsp_valid` falls to 0 asynchronously, and after release the first grant goes to requester 0.
